c17_bist_ctrl: RTL and testbench

- Built-in self-test controller: the driving and observing end of the c17 ISCAS benchmark netlist.
- Generates pseudo-random 5-bit input patterns with an LFSR and applies them to the c17 inputs.
- Compacts the 2-bit c17 responses into an 8-bit MISR signature and compares the final signature against a golden value.
- Sits beside the combinational c17 instance in the PA1 test wrapper.

---
 rtl/c17_bist_if.sv | 29 ++
 rtl/c17_bist_ctrl.sv | 91 +++++++++
 tb/tb_c17_bist_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c17_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : c17_bist_if
// Brief    : Pattern/response/status bundle between the BIST controller and
//            the test wrapper that hosts the c17 netlist.
// Revision : 1.0 - initial release
// ============================================================================
interface c17_bist_if;
  logic       start;
  logic [7:0] golden_sig;
  logic [1:0] resp_in;
  logic [4:0] pat_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;
  logic [4:0] pat_cnt;

  modport master (
    output start, golden_sig, resp_in,
    input  pat_out, busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, golden_sig, resp_in,
    output pat_out, busy, done, pass, signature, pat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/c17_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : c17_bist_ctrl
// Brief    : LFSR pattern generator + 8-bit MISR compactor with golden-signature
//            compare for the combinational c17 benchmark.
// Revision : 1.0 - initial release
// ============================================================================
module c17_bist_ctrl #(
  parameter int         NUM_PATTERNS = 31,
  parameter logic [4:0] LFSR_SEED    = 5'b00001,
  parameter logic [7:0] MISR_SEED    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  c17_bist_if.slave  bus
);

  generate
    if (NUM_PATTERNS < 1 || NUM_PATTERNS > 31) begin : g_bad_num_patterns
      $error("c17_bist_ctrl: NUM_PATTERNS must be in 1..31");
    end
    if (LFSR_SEED == 5'd0) begin : g_bad_lfsr_seed
      $error("c17_bist_ctrl: LFSR_SEED must be non-zero");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] c_last_cnt = 5'(NUM_PATTERNS - 1);

  logic [1:0] r_state;
  logic [4:0] r_lfsr;
  logic [7:0] r_misr;
  logic [4:0] r_cnt;
  logic       r_pass;

  logic [4:0] w_lfsr_nxt;
  logic [7:0] w_misr_nxt;
  logic       w_last;

  // x^5+x^3+1 Fibonacci LFSR; MISR taps 7,5,4,3 with response folded into bits 1:0
  assign w_lfsr_nxt = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
  assign w_misr_nxt = {r_misr[6:0], r_misr[7] ^ r_misr[5] ^ r_misr[4] ^ r_misr[3]}
                      ^ {6'b0, bus.resp_in};
  assign w_last     = (r_cnt == c_last_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= 5'd0;
      r_misr  <= 8'h00;
      r_cnt   <= 5'd0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_lfsr  <= LFSR_SEED;
            r_misr  <= MISR_SEED;
            r_cnt   <= 5'd0;
            r_pass  <= 1'b0;
          end
        end
        S_RUN: begin
          r_misr <= w_misr_nxt;
          r_cnt  <= r_cnt + 5'd1;
          // The LFSR is frozen on the final edge so pat_out keeps the last pattern
          if (w_last) begin
            r_state <= S_DONE;
            r_pass  <= (w_misr_nxt == bus.golden_sig);
          end else begin
            r_lfsr  <= w_lfsr_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pat_out   = r_lfsr;
  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.pass      = r_pass;
  assign bus.signature = r_misr;
  assign bus.pat_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_c17_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_c17_bist_ctrl
// Brief    : Self-checking bench: c17 + MISR reference model, scoreboard queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c17_bist_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sa0   = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [4:0] q_pat[$];
  logic [7:0] q_sig[$];

  c17_bist_if if0();
  c17_bist_if if1();

  c17_bist_ctrl #(.NUM_PATTERNS(31), .LFSR_SEED(5'b00001), .MISR_SEED(8'h00)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );

  c17_bist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(5'b00001), .MISR_SEED(8'h00)) u_one (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] c17(input logic [4:0] p);
    logic g1, g2, g3, g6, g7, n10, n11, n16, n19;
    g1 = p[4]; g2 = p[3]; g3 = p[2]; g6 = p[1]; g7 = p[0];
    n10 = ~(g1 & g3);
    n11 = ~(g3 & g6);
    n16 = ~(g2 & n11);
    n19 = ~(n11 & g7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  logic [1:0] w_c17;
  assign w_c17       = c17(if0.pat_out);
  assign if0.resp_in = {w_c17[1] & ~sa0, w_c17[0]};

  // Reference: patterns from the polynomial, signature from c17 + MISR
  task automatic model(input int n, input logic fault, input logic push,
                       output logic [7:0] sig);
    logic [4:0] l;
    logic [7:0] m;
    logic [1:0] r;
    l = 5'b00001;
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (push) q_pat.push_back(l);
      r = c17(l);
      if (fault) r[1] = 1'b0;
      m = {m[6:0], ^(m & 8'hB8)} ^ {6'b000000, r};
      l = {l[3:0], l[4] ^ l[2]};
    end
    sig = m;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input int extra_at, output int lat);
    lat = -1;
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (if0.done === 1'b1) begin
        lat = n;
        break;
      end
      if0.start = (n == extra_at);
      tick;
    end
    if0.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if ({if0.busy, if0.done, if0.pass, if0.pat_out, if0.signature, if0.pat_cnt} !== 21'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: busy=%b done=%b pass=%b pat=%b sig=%h cnt=%0d, required all zero",
                 i, if0.busy, if0.done, if0.pass, if0.pat_out, if0.signature, if0.pat_cnt);
      end
    end
  endtask

  task automatic test_pattern_seq;
    logic [7:0]  sig;
    logic [4:0]  exp, last;
    logic [31:0] seen;
    int          lat;
    q_pat.delete();
    model(31, 1'b0, 1'b1, sig);
    q_sig.push_back(sig);
    if0.golden_sig = sig;
    seen = 32'd0;
    last = 5'd0;
    lat  = -1;
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (if0.done === 1'b1) begin
        lat = n;
        break;
      end
      if (if0.busy === 1'b1) begin
        checks++;
        if (q_pat.size() == 0) begin
          errors++;
          $display("FAIL pat_extra run_cyc=%0d: got pattern %b, required none", n, if0.pat_out);
        end else begin
          exp = q_pat.pop_front();
          last = exp;
          if (if0.pat_out !== exp) begin
            errors++;
            $display("FAIL pat_seq run_cyc=%0d: got %b, required %b", n, if0.pat_out, exp);
          end
        end
        seen[if0.pat_out] = 1'b1;
      end
      tick;
    end
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL done_latency: got %0d, required 32", lat);
    end
    checks++;
    if (seen !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL pat_coverage: seen=%h, required fffffffe", seen);
    end
    checks++;
    if (q_pat.size() != 0) begin
      errors++;
      $display("FAIL pat_missing: %0d patterns not applied, required 0", q_pat.size());
    end
    checks++;
    if (if0.pat_out !== last) begin
      errors++;
      $display("FAIL pat_hold_done: got %b, required %b", if0.pat_out, last);
    end
    exp = 5'd0;
    sig = q_sig.pop_front();
    checks++;
    if (if0.signature !== sig || if0.pass !== 1'b1) begin
      errors++;
      $display("FAIL seq_signature: sig=%h pass=%b, required sig=%h pass=1", if0.signature, if0.pass, sig);
    end
  endtask

  task automatic test_single;
    logic [7:0] gold[2];
    logic [7:0] sig;
    int         lat;
    gold[0] = 8'h03;
    gold[1] = 8'h02;
    if1.resp_in = 2'b11;
    for (int k = 0; k < 2; k++) begin
      q_sig.push_back(8'h03);
      if1.golden_sig = gold[k];
      lat = -1;
      if1.start = 1'b1;
      tick;
      if1.start = 1'b0;
      for (int n = 1; n <= 5; n++) begin
        if (if1.done === 1'b1) begin
          lat = n;
          break;
        end
        tick;
      end
      sig = q_sig.pop_front();
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL single_latency gold=%h: got %0d, required 2", gold[k], lat);
      end
      checks++;
      if (if1.signature !== sig || if1.pat_cnt !== 5'd1 || if1.busy !== 1'b0) begin
        errors++;
        $display("FAIL single_state gold=%h: sig=%h cnt=%0d busy=%b, required sig=%h cnt=1 busy=0",
                 gold[k], if1.signature, if1.pat_cnt, if1.busy, sig);
      end
      checks++;
      if (if1.pass !== (k == 0)) begin
        errors++;
        $display("FAIL single_pass gold=%h: got %b, required %b", gold[k], if1.pass, (k == 0));
      end
      tick;
    end
  endtask

  task automatic test_full_run;
    logic [7:0] good, sig;
    int         lat;
    model(31, 1'b0, 1'b0, good);
    if0.golden_sig = good;
    for (int f = 0; f < 2; f++) begin
      model(31, f[0], 1'b0, sig);
      q_sig.push_back(sig);
      sa0 = f[0];
      run0(0, lat);
      sig = q_sig.pop_front();
      checks++;
      if (lat !== 32 || if0.signature !== sig || if0.pat_cnt !== 5'd31 || if0.busy !== 1'b0) begin
        errors++;
        $display("FAIL full_run fault=%0d: lat=%0d sig=%h cnt=%0d busy=%b, required lat=32 sig=%h cnt=31 busy=0",
                 f, lat, if0.signature, if0.pat_cnt, if0.busy, sig);
      end
      checks++;
      if (if0.pass !== (f == 0)) begin
        errors++;
        $display("FAIL full_pass fault=%0d: got %b, required %b", f, if0.pass, (f == 0));
      end
    end
    sa0 = 1'b0;
    tick;
  endtask

  task automatic test_protocol;
    logic [7:0] good, sig;
    int         lat;
    model(31, 1'b0, 1'b0, good);
    if0.golden_sig = good;

    q_sig.push_back(good);
    run0(10, lat);
    sig = q_sig.pop_front();
    checks++;
    if (lat !== 32 || if0.signature !== sig || if0.pass !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run: lat=%0d sig=%h pass=%b, required lat=32 sig=%h pass=1",
               lat, if0.signature, if0.pass, sig);
    end

    // Restart from DONE: done/pass clear on the start edge, rerun matches
    q_sig.push_back(good);
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    checks++;
    if (if0.done !== 1'b0 || if0.pass !== 1'b0 || if0.busy !== 1'b1 || if0.pat_cnt !== 5'd0) begin
      errors++;
      $display("FAIL restart_clear: done=%b pass=%b busy=%b cnt=%0d, required 0 0 1 0",
               if0.done, if0.pass, if0.busy, if0.pat_cnt);
    end
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (if0.done === 1'b1) begin
        lat = n;
        break;
      end
      tick;
    end
    sig = q_sig.pop_front();
    checks++;
    if (lat !== 32 || if0.signature !== sig || if0.pass !== 1'b1) begin
      errors++;
      $display("FAIL rerun_identical: lat=%0d sig=%h pass=%b, required lat=32 sig=%h pass=1",
               lat, if0.signature, if0.pass, sig);
    end

    // Reset in RUN cycle 15
    if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    for (int n = 1; n < 15; n++) tick;
    checks++;
    if (if0.busy !== 1'b1 || if0.pat_cnt !== 5'd14) begin
      errors++;
      $display("FAIL run_cyc15: busy=%b cnt=%0d, required busy=1 cnt=14", if0.busy, if0.pat_cnt);
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++;
    if ({if0.busy, if0.done, if0.pass, if0.pat_out, if0.signature, if0.pat_cnt} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b pass=%b pat=%b sig=%h cnt=%0d, required all zero",
               if0.busy, if0.done, if0.pass, if0.pat_out, if0.signature, if0.pat_cnt);
    end

    // start coincident with reset
    rst_n = 1'b0;
    if0.start = 1'b1;
    tick;
    rst_n = 1'b1;
    if0.start = 1'b0;
    tick;
    checks++;
    if (if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.pat_out !== 5'd0) begin
      errors++;
      $display("FAIL start_with_reset: busy=%b done=%b pat=%b, required 0 0 00000",
               if0.busy, if0.done, if0.pat_out);
    end
  endtask

  initial begin
    if0.start      = 1'b0;
    if0.golden_sig = 8'h00;
    if1.start      = 1'b0;
    if1.golden_sig = 8'h00;
    if1.resp_in    = 2'b00;
    test_reset;
    test_pattern_seq;
    test_single;
    test_full_run;
    test_protocol;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
